control_unit: RTL and testbench

//  Multi-cycle control FSM: fetches 8-bit instructions, decodes them and drives the datapath strobes.

---
 rtl/control_unit.sv | 169 ++++++++++++++++
 tb/tb_control_unit.sv | 309 ++++++++++++++++++++++++++++++
 2 files changed

// File: rtl/control_unit.sv
// rtl/control_unit.sv - multi-cycle fetch/decode/execute control FSM with memory wait handshake
// Strobes are decoded from state and opcode; only IR_LD, PC_INC and ACC_LD see MEM_RDY combinationally.
module control_unit #(
  parameter int WAIT_MAX = 8
) (
  input  logic       CLK,
  input  logic       nRST,
  input  logic [7:0] INSTR,
  input  logic       MEM_RDY,
  input  logic       ALU_Z,
  output logic       MEM_RD,
  output logic       MEM_WR,
  output logic       IR_LD,
  output logic       PC_INC,
  output logic [1:0] JUMP,
  output logic       ZF,
  output logic [2:0] ALU_OP,
  output logic       SRC_SEL,
  output logic       ACC_LD,
  output logic       HALTED,
  output logic       FAULT
);

  localparam int CW = (WAIT_MAX < 2) ? 1 : $clog2(WAIT_MAX);
  localparam logic [CW-1:0] CNT_LAST = CW'(WAIT_MAX - 1);

  localparam logic [3:0] OP_NOP = 4'h0;
  localparam logic [3:0] OP_LDI = 4'h1;
  localparam logic [3:0] OP_OR  = 4'h5;
  localparam logic [3:0] OP_LD  = 4'h6;
  localparam logic [3:0] OP_ST  = 4'h7;
  localparam logic [3:0] OP_JMP = 4'h8;
  localparam logic [3:0] OP_JZ  = 4'h9;
  localparam logic [3:0] OP_JNZ = 4'hA;
  localparam logic [3:0] OP_HLT = 4'hF;

  typedef enum logic [2:0] {
    S_FETCH,
    S_DECODE,
    S_EXEC,
    S_MEM,
    S_HALT
  } state_t;

  state_t        state;
  logic [3:0]    ir_op;
  logic [CW-1:0] cnt;
  logic          zf_q;
  logic          fault_q;

  // The immediate feeds the datapath directly; control only needs the opcode.
  logic unused_imm;
  assign unused_imm = ^INSTR[3:0];

  logic       is_alu;
  logic       rd_d, wr_d, ir_ld_d, acc_ld_d, src_sel_d, halted_d;
  logic [1:0] jump_d;
  logic [2:0] alu_op_d;

  assign is_alu = (ir_op >= OP_LDI) && (ir_op <= OP_OR);

  always_comb begin
    rd_d      = 1'b0;
    wr_d      = 1'b0;
    ir_ld_d   = 1'b0;
    acc_ld_d  = 1'b0;
    src_sel_d = 1'b0;
    halted_d  = 1'b0;
    jump_d    = 2'b00;
    alu_op_d  = 3'b000;
    case (state)
      S_FETCH: begin
        rd_d    = 1'b1;
        ir_ld_d = MEM_RDY;
      end
      S_EXEC: begin
        if (is_alu) begin
          alu_op_d = ir_op[2:0] - 3'd1;
          acc_ld_d = 1'b1;
        end
        case (ir_op)
          OP_JMP:  jump_d = 2'b01;
          OP_JZ:   jump_d = 2'b10;
          OP_JNZ:  jump_d = 2'b11;
          default: jump_d = 2'b00;
        endcase
      end
      S_MEM: begin
        if (ir_op == OP_LD) begin
          rd_d      = 1'b1;
          src_sel_d = 1'b1;
          acc_ld_d  = MEM_RDY;
        end else begin
          wr_d = 1'b1;
        end
      end
      S_HALT:  halted_d = 1'b1;
      default: ;
    endcase
  end

  // Gating with nRST drops requests the moment reset asserts, without waiting for a clock.
  assign MEM_RD  = nRST & rd_d;
  assign MEM_WR  = nRST & wr_d;
  assign IR_LD   = nRST & ir_ld_d;
  assign PC_INC  = nRST & ir_ld_d;
  assign ACC_LD  = nRST & acc_ld_d;
  assign SRC_SEL = nRST & src_sel_d;
  assign HALTED  = nRST & halted_d;
  assign JUMP    = nRST ? jump_d : 2'b00;
  assign ALU_OP  = nRST ? alu_op_d : 3'b000;
  assign ZF      = zf_q;
  assign FAULT   = fault_q;

  always_ff @(posedge CLK or negedge nRST) begin
    if (!nRST) begin
      state   <= S_FETCH;
      ir_op   <= 4'h0;
      cnt     <= '0;
      zf_q    <= 1'b0;
      fault_q <= 1'b0;
    end else begin
      if (acc_ld_d) zf_q <= ALU_Z;
      case (state)
        S_FETCH: begin
          if (MEM_RDY) begin
            ir_op <= INSTR[7:4];
            cnt   <= '0;
            state <= S_DECODE;
          end else if (cnt == CNT_LAST) begin
            fault_q <= 1'b1;
            state   <= S_HALT;
          end else begin
            cnt <= cnt + 1'b1;
          end
        end
        S_DECODE: begin
          cnt <= '0;
          if (ir_op == OP_HLT)
            state <= S_HALT;
          else if (ir_op == OP_LD || ir_op == OP_ST)
            state <= S_MEM;
          else if (ir_op == OP_NOP || ir_op > OP_JNZ)
            state <= S_FETCH;
          else
            state <= S_EXEC;
        end
        S_EXEC: begin
          cnt   <= '0;
          state <= S_FETCH;
        end
        S_MEM: begin
          if (MEM_RDY) begin
            cnt   <= '0;
            state <= S_FETCH;
          end else if (cnt == CNT_LAST) begin
            fault_q <= 1'b1;
            state   <= S_HALT;
          end else begin
            cnt <= cnt + 1'b1;
          end
        end
        S_HALT:  state <= S_HALT;
        default: state <= S_FETCH;
      endcase
    end
  end

endmodule

// File: tb/tb_control_unit.sv
// tb/tb_control_unit.sv - directed-vector bench for control_unit
// Inputs change and outputs are sampled 1 time unit after the falling edge.
module tb_control_unit;

  logic       CLK = 1'b0;
  logic       nRST = 1'b0;
  logic [7:0] INSTR = 8'h00;
  logic       MEM_RDY = 1'b0;
  logic       ALU_Z = 1'b0;
  logic       MEM_RD, MEM_WR, IR_LD, PC_INC, ZF, SRC_SEL, ACC_LD, HALTED, FAULT;
  logic [1:0] JUMP;
  logic [2:0] ALU_OP;

  int tests = 0;
  int fails = 0;

  control_unit #(.WAIT_MAX(4)) dut (
    .CLK(CLK), .nRST(nRST), .INSTR(INSTR), .MEM_RDY(MEM_RDY), .ALU_Z(ALU_Z),
    .MEM_RD(MEM_RD), .MEM_WR(MEM_WR), .IR_LD(IR_LD), .PC_INC(PC_INC), .JUMP(JUMP),
    .ZF(ZF), .ALU_OP(ALU_OP), .SRC_SEL(SRC_SEL), .ACC_LD(ACC_LD), .HALTED(HALTED),
    .FAULT(FAULT)
  );

  always #5 CLK = ~CLK;

  task automatic next_cycle();
    @(negedge CLK);
  endtask

  // Present one instruction in FETCH with MEM_RDY=1; returns in the DECODE cycle.
  task automatic fetch(input logic [7:0] ins);
    MEM_RDY = 1'b1;
    INSTR = ins;
    #1;
    tests++;
    if ({MEM_RD, IR_LD, PC_INC} !== 3'b111) begin
      fails++; $display("FAIL fetch_%h: rd/ir_ld/pc_inc=%b required 111", ins, {MEM_RD, IR_LD, PC_INC});
    end
    next_cycle();
    MEM_RDY = 1'b0;
  endtask

  task automatic test_reset();
    nRST = 1'b0;
    #3;
    tests++;
    if ({MEM_RD, MEM_WR, IR_LD, PC_INC, JUMP, ZF, ALU_OP, SRC_SEL, ACC_LD, HALTED, FAULT} !== 14'h0) begin
      fails++; $display("FAIL reset_outputs: got %b required all zero",
        {MEM_RD, MEM_WR, IR_LD, PC_INC, JUMP, ZF, ALU_OP, SRC_SEL, ACC_LD, HALTED, FAULT});
    end
    next_cycle();
    nRST = 1'b1;
    #1;
    tests++;
    if ({MEM_RD, ZF, HALTED} !== 3'b100) begin
      fails++; $display("FAIL release_fetch: rd/zf/halted=%b required 100", {MEM_RD, ZF, HALTED});
    end
    @(posedge CLK);
    #2;
    nRST = 1'b0;
    #1;
    tests++;
    if (MEM_RD !== 1'b0) begin
      fails++; $display("FAIL async_drop: MEM_RD=%b required 0", MEM_RD);
    end
    next_cycle();
    nRST = 1'b1;
    #1;
    tests++;
    if ({MEM_RD, ZF} !== 2'b10) begin
      fails++; $display("FAIL rerelease: rd/zf=%b required 10", {MEM_RD, ZF});
    end
  endtask

  task automatic test_fetch_wait();
    int bad = 0;
    for (int i = 0; i < 3; i++) begin
      MEM_RDY = 1'b0;
      #1;
      if ({MEM_RD, IR_LD, PC_INC} !== 3'b100) bad++;
      next_cycle();
    end
    tests++;
    if (bad != 0) begin
      fails++; $display("FAIL fetch_wait: %0d bad wait cycles required 0", bad);
    end
    fetch(8'h00);
    #1;
    tests++;
    if ({MEM_RD, IR_LD, PC_INC} !== 3'b000) begin
      fails++; $display("FAIL decode_after_fetch: rd/ir_ld/pc_inc=%b required 000", {MEM_RD, IR_LD, PC_INC});
    end
    next_cycle();
    #1;
    tests++;
    if (MEM_RD !== 1'b1) begin
      fails++; $display("FAIL nop_refetch: MEM_RD=%b required 1", MEM_RD);
    end
  endtask

  task automatic test_ldi_jz();
    fetch(8'h10);
    #1;
    tests++;
    if ({JUMP, ACC_LD} !== 3'b000) begin
      fails++; $display("FAIL ldi_decode: jump/acc_ld=%b required 000", {JUMP, ACC_LD});
    end
    next_cycle();
    ALU_Z = 1'b1;
    #1;
    tests++;
    if ({ACC_LD, ALU_OP, SRC_SEL} !== 5'b1_000_0) begin
      fails++; $display("FAIL ldi_exec: acc_ld/alu_op/src_sel=%b required 10000", {ACC_LD, ALU_OP, SRC_SEL});
    end
    next_cycle();
    ALU_Z = 1'b0;
    #1;
    tests++;
    if (ZF !== 1'b1) begin
      fails++; $display("FAIL ldi_zf: ZF=%b required 1", ZF);
    end
    fetch(8'h93);
    next_cycle();
    #1;
    tests++;
    if ({JUMP, ZF} !== 3'b10_1) begin
      fails++; $display("FAIL jz_exec: jump/zf=%b required 101", {JUMP, ZF});
    end
    next_cycle();
    #1;
    tests++;
    if (JUMP !== 2'b00) begin
      fails++; $display("FAIL jz_one_cycle: JUMP=%b required 00", JUMP);
    end
  endtask

  task automatic test_add_jumps();
    logic [7:0] ins [3] = '{8'h31, 8'h42, 8'h53};
    logic [2:0] exp [3] = '{3'b010, 3'b011, 3'b100};
    fetch(8'h25);
    next_cycle();
    ALU_Z = 1'b0;
    #1;
    tests++;
    if ({ACC_LD, ALU_OP} !== 4'b1_001) begin
      fails++; $display("FAIL add_exec: acc_ld/alu_op=%b required 1001", {ACC_LD, ALU_OP});
    end
    next_cycle();
    #1;
    tests++;
    if (ZF !== 1'b0) begin
      fails++; $display("FAIL add_zf: ZF=%b required 0", ZF);
    end
    fetch(8'hA0);
    next_cycle();
    #1;
    tests++;
    if (JUMP !== 2'b11) begin
      fails++; $display("FAIL jnz_exec: JUMP=%b required 11", JUMP);
    end
    next_cycle();
    fetch(8'h80);
    next_cycle();
    #1;
    tests++;
    if (JUMP !== 2'b01) begin
      fails++; $display("FAIL jmp_exec: JUMP=%b required 01", JUMP);
    end
    next_cycle();
    for (int i = 0; i < 3; i++) begin
      fetch(ins[i]);
      next_cycle();
      #1;
      tests++;
      if ({ACC_LD, ALU_OP} !== {1'b1, exp[i]}) begin
        fails++; $display("FAIL alu_op_%h: acc_ld/alu_op=%b required %b", ins[i], {ACC_LD, ALU_OP}, {1'b1, exp[i]});
      end
      next_cycle();
    end
  endtask

  task automatic test_mem_ops();
    fetch(8'h60);
    next_cycle();
    MEM_RDY = 1'b1;
    ALU_Z = 1'b1;
    #1;
    tests++;
    if ({MEM_RD, MEM_WR, SRC_SEL, ACC_LD, ALU_OP} !== 7'b1011_000) begin
      fails++; $display("FAIL ld_ready: rd/wr/src/acc/op=%b required 1011000", {MEM_RD, MEM_WR, SRC_SEL, ACC_LD, ALU_OP});
    end
    next_cycle();
    MEM_RDY = 1'b0;
    ALU_Z = 1'b0;
    #1;
    tests++;
    if (ZF !== 1'b1) begin
      fails++; $display("FAIL ld_zf: ZF=%b required 1", ZF);
    end
    fetch(8'h70);
    next_cycle();
    #1;
    tests++;
    if ({MEM_RD, MEM_WR, ACC_LD} !== 3'b010) begin
      fails++; $display("FAIL st_wait: rd/wr/acc=%b required 010", {MEM_RD, MEM_WR, ACC_LD});
    end
    next_cycle();
    MEM_RDY = 1'b1;
    #1;
    tests++;
    if ({MEM_WR, ACC_LD} !== 2'b10) begin
      fails++; $display("FAIL st_ready: wr/acc=%b required 10", {MEM_WR, ACC_LD});
    end
    next_cycle();
    MEM_RDY = 1'b0;
    #1;
    tests++;
    if ({MEM_WR, MEM_RD, ZF} !== 3'b011) begin
      fails++; $display("FAIL st_done: wr/rd/zf=%b required 011", {MEM_WR, MEM_RD, ZF});
    end
    fetch(8'hB0);
    next_cycle();
    #1;
    tests++;
    if ({MEM_RD, JUMP, ACC_LD} !== 4'b1000) begin
      fails++; $display("FAIL undefined_op: rd/jump/acc=%b required 1000", {MEM_RD, JUMP, ACC_LD});
    end
  endtask

  task automatic test_ld_fault();
    int bad = 0;
    fetch(8'h60);
    next_cycle();
    for (int i = 0; i < 4; i++) begin
      #1;
      if ({MEM_RD, ACC_LD, FAULT} !== 3'b100) bad++;
      next_cycle();
    end
    tests++;
    if (bad != 0) begin
      fails++; $display("FAIL ld_wait: %0d bad wait cycles required 0", bad);
    end
    #1;
    tests++;
    if ({FAULT, HALTED, MEM_RD, ACC_LD} !== 4'b1100) begin
      fails++; $display("FAIL ld_timeout: fault/halted/rd/acc=%b required 1100", {FAULT, HALTED, MEM_RD, ACC_LD});
    end
  endtask

  task automatic test_halt();
    int bad = 0;
    nRST = 1'b0;
    #1;
    tests++;
    if ({FAULT, HALTED} !== 2'b00) begin
      fails++; $display("FAIL fault_clear: fault/halted=%b required 00", {FAULT, HALTED});
    end
    next_cycle();
    nRST = 1'b1;
    fetch(8'h10);
    next_cycle();
    ALU_Z = 1'b1;
    next_cycle();
    ALU_Z = 1'b0;
    fetch(8'hF0);
    next_cycle();
    for (int i = 0; i < 20; i++) begin
      MEM_RDY = i[0];
      #1;
      if ({HALTED, MEM_RD, MEM_WR, IR_LD, ACC_LD, JUMP} !== 7'b1000000) bad++;
      next_cycle();
    end
    MEM_RDY = 1'b0;
    tests++;
    if (bad != 0) begin
      fails++; $display("FAIL halt_hold: %0d bad halt cycles required 0", bad);
    end
    tests++;
    if (ZF !== 1'b1) begin
      fails++; $display("FAIL halt_zf: ZF=%b required 1", ZF);
    end
    nRST = 1'b0;
    #1;
    tests++;
    if ({HALTED, FAULT, ZF} !== 3'b000) begin
      fails++; $display("FAIL halt_reset: halted/fault/zf=%b required 000", {HALTED, FAULT, ZF});
    end
    next_cycle();
    nRST = 1'b1;
    #1;
    tests++;
    if ({MEM_RD, HALTED} !== 2'b10) begin
      fails++; $display("FAIL halt_resume: rd/halted=%b required 10", {MEM_RD, HALTED});
    end
  endtask

  initial begin
    test_reset();
    test_fetch_wait();
    test_ldi_jz();
    test_add_jumps();
    test_mem_ops();
    test_ld_fault();
    test_halt();
    $display("[TB] %0d tests run, %0d failed", tests, fails);
    $finish;
  end

endmodule
